// File: rtl/fetch_port_arbiter.sv
// rtl/fetch_port_arbiter.sv - round-robin arbiter sharing one fetch engine among NUM_REQ buffer loaders
// Owner tracking decides when the engine tile pointer must be reset; a watchdog bounds each fetch.
module fetch_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT_W = 12,
  parameter int TIMEOUT   = 2048
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_sel,
  input  logic [NUM_REQ-1:0]   req_tiles,
  input  logic [NUM_REQ-1:0]   req_rst_ptr,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 start_fetch,
  output logic                 reset_addr_counter,
  output logic [2:0]           Offset_Control,
  output logic                 Tiles_Control,
  input  logic                 fetch_done,
  output logic                 err_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    WAIT,
    RELEASE
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     last;
  logic [IDX_W-1:0]     prev_owner;
  logic                 prev_valid;
  logic                 hold_off;
  logic [TIMEOUT_W-1:0] wdog;

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [2:0]           sel_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sel
    assign sel_arr[g] = req_sel[3*g +: 3];
  end

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int step);
    return IDX_W'((int'(base) + step) % NUM_REQ);
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Circular search starting just after the previous winner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_valid && req[wrap_idx(last, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(last, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      owner              <= '0;
      last               <= IDX_W'(NUM_REQ - 1);
      prev_owner         <= '0;
      prev_valid         <= 1'b0;
      hold_off           <= 1'b0;
      wdog               <= '0;
      grant              <= '0;
      done               <= '0;
      start_fetch        <= 1'b0;
      reset_addr_counter <= 1'b0;
      Offset_Control     <= 3'd0;
      Tiles_Control      <= 1'b0;
      err_timeout        <= 1'b0;
    end else begin
      done               <= '0;
      start_fetch        <= 1'b0;
      reset_addr_counter <= 1'b0;
      case (state)
        IDLE: begin
          // The cycle after a release is skipped so the served requester can drop req first.
          if (hold_off) begin
            hold_off <= 1'b0;
          end else if (pick_valid) begin
            owner              <= pick_idx;
            last               <= pick_idx;
            grant              <= one_hot(pick_idx);
            Offset_Control     <= sel_arr[pick_idx];
            Tiles_Control      <= req_tiles[pick_idx];
            reset_addr_counter <= !prev_valid || (prev_owner != pick_idx) || req_rst_ptr[pick_idx];
            prev_owner         <= pick_idx;
            prev_valid         <= 1'b1;
            state              <= SETUP;
          end
        end
        SETUP: begin
          start_fetch <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (fetch_done) begin
            done  <= one_hot(owner);
            state <= RELEASE;
          end else if (wdog == WDOG_LAST) begin
            err_timeout <= 1'b1;
            done        <= one_hot(owner);
            state       <= RELEASE;
          end else begin
            wdog <= wdog + TIMEOUT_W'(1);
          end
        end
        RELEASE: begin
          // Burst under lock keeps the engine pointer unless the owner asks for a reset.
          if (req_lock[owner]) begin
            Offset_Control     <= sel_arr[owner];
            Tiles_Control      <= req_tiles[owner];
            reset_addr_counter <= req_rst_ptr[owner];
            state              <= SETUP;
          end else begin
            grant    <= '0;
            hold_off <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_port_arbiter.sv
// tb/tb_fetch_port_arbiter.sv - scoreboard bench for fetch_port_arbiter
// A tile-level model predicts grant order, pointer resets, latencies and timeouts.
module tb_fetch_port_arbiter;

  localparam int N  = 4;
  localparam int TW = 12;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] req_sel = '0;
  logic [N-1:0]   req_tiles = '0;
  logic [N-1:0]   req_rst_ptr = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           start_fetch;
  logic           reset_addr_counter;
  logic [2:0]     Offset_Control;
  logic           Tiles_Control;
  logic           fetch_done = 1'b0;
  logic           err_timeout;

  always #5 clk = ~clk;

  fetch_port_arbiter #(.NUM_REQ(N), .TIMEOUT_W(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel), .req_tiles(req_tiles),
    .req_rst_ptr(req_rst_ptr), .req_lock(req_lock), .grant(grant), .done(done),
    .start_fetch(start_fetch), .reset_addr_counter(reset_addr_counter),
    .Offset_Control(Offset_Control), .Tiles_Control(Tiles_Control),
    .fetch_done(fetch_done), .err_timeout(err_timeout)
  );

  typedef struct {
    int owner;
    int sel;
    int tiles;
    bit rac;
    int gap;
    int delay;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   eng_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int m_last = N - 1;
  int m_prev = 0;
  bit m_pv   = 1'b0;
  bit m_err  = 1'b0;
  int rem[N];
  bit lk[N];
  int sel_v[N];
  int tiles_v[N];

  task automatic check(input string name, input longint act, input longint want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, want);
    end
  endtask

  function automatic int pick_delay(input bit allow_stall);
    int r;
    r = $urandom_range(0, 19);
    if (allow_stall && r < 3) return 0;
    if (r < 5) return TO;
    return $urandom_range(1, 8);
  endfunction

  // Tile sequence: round robin over requesters with tiles left; a locked requester
  // keeps the port until its tiles are exhausted.
  task automatic gen_model(input bit [N-1:0] rst_m, input bit allow_stall, input int force_d,
                           output int n_tiles);
    int r[N];
    int o;
    bit first;
    bit cont;
    exp_t e;
    r       = rem;
    first   = 1'b1;
    n_tiles = 0;
    forever begin
      o = -1;
      for (int k = 1; k <= N; k++)
        if (o < 0 && r[(m_last + k) % N] > 0) o = (m_last + k) % N;
      if (o < 0) break;
      m_last = o;
      cont   = 1'b0;
      do begin
        e.owner = o;
        e.sel   = sel_v[o];
        e.tiles = tiles_v[o];
        e.rac   = !m_pv || (m_prev != o) || rst_m[o];
        e.gap   = first ? 0 : (cont ? 2 : 4);
        e.delay = (force_d >= 0) ? force_d : pick_delay(allow_stall);
        if (e.delay == 0) m_err = 1'b1;
        e.err   = m_err;
        m_pv    = 1'b1;
        m_prev  = o;
        exp_q.push_back(e);
        eng_q.push_back(e.delay);
        n_tiles++;
        first   = 1'b0;
        r[o]--;
        cont    = lk[o] && r[o] > 0;
      end while (cont);
    end
  endtask

  task automatic drive_reqs(input bit [N-1:0] rst_m);
    for (int i = 0; i < N; i++) begin
      req[i]           = rem[i] > 0;
      req_lock[i]      = lk[i] && rem[i] > 1;
      req_rst_ptr[i]   = rst_m[i];
      req_sel[3*i +: 3] = 3'(sel_v[i]);
      req_tiles[i]     = tiles_v[i][0];
    end
  endtask

  task automatic run_batch(input bit [N-1:0] mask, input int rem_fix, input bit [N-1:0] lock_m,
                           input bit [N-1:0] rst_m, input int sel0, input bit allow_stall,
                           input int force_d);
    int n;
    int seen;
    int idx;
    for (int i = 0; i < N; i++) begin
      rem[i]     = mask[i] ? ((rem_fix > 0) ? rem_fix : int'($urandom_range(1, 3))) : 0;
      lk[i]      = lock_m[i];
      sel_v[i]   = (i == 0 && sel0 >= 0) ? sel0 : int'($urandom_range(0, 7));
      tiles_v[i] = $urandom_range(0, 1);
    end
    gen_model(rst_m, allow_stall, force_d, n);
    @(posedge clk);
    #1;
    drive_reqs(rst_m);
    seen = 0;
    for (int c = 0; c < 3000 && seen < n; c++) begin
      @(negedge clk);
      if (done != 0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (done[i]) idx = i;
        seen++;
        @(posedge clk);
        #1;
        if (rem[idx] > 0) rem[idx]--;
        if (rem[idx] == 0) begin
          req[idx]      = 1'b0;
          req_lock[idx] = 1'b0;
        end else begin
          req_lock[idx] = lk[idx] && rem[idx] > 1;
        end
      end
    end
    check("batch_tiles_completed", seen, n);
    req         = '0;
    req_lock    = '0;
    req_rst_ptr = '0;
    repeat (3) @(negedge clk);
    check("idle_grant", grant, 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin : engine
    int d;
    forever begin
      @(negedge clk);
      if (rst_n && start_fetch) begin
        d = (eng_q.size() > 0) ? eng_q.pop_front() : 0;
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1 fetch_done = 1'b1;
          @(posedge clk);
          #1 fetch_done = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t cur;
    bit   active;
    int   start_cyc;
    int   last_done;
    int   rac_cyc;
    active    = 1'b0;
    start_cyc = 0;
    last_done = -100;
    rac_cyc   = -100;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active  = 1'b0;
        rac_cyc = -100;
      end else begin
        if (reset_addr_counter) rac_cyc = cyc;
        if (start_fetch) begin
          if (exp_q.size() == 0) begin
            check("unexpected_start_fetch", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            check("grant_at_start", grant, longint'(1) << cur.owner);
            check("offset_control", Offset_Control, cur.sel);
            check("tiles_control", Tiles_Control, cur.tiles);
            check("reset_addr_counter_before_start", (rac_cyc == cyc - 1), cur.rac);
            if (cur.gap != 0) check("done_to_start_gap", cyc - last_done, cur.gap);
            active    = 1'b1;
            start_cyc = cyc;
          end
        end
        if (done != 0) begin
          if (!active) begin
            check("unexpected_done", done, 0);
          end else begin
            check("done_owner", done, longint'(1) << cur.owner);
            check("err_timeout_at_done", err_timeout, cur.err);
            check("done_latency", cyc - start_cyc, (cur.delay == 0) ? TO + 1 : cur.delay + 1);
            last_done = cyc;
            active    = 1'b0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int  n;
    bit  saw_done;
    bit  started;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_grant", grant, 0);
    check("reset_done", done, 0);
    check("reset_start_fetch", start_fetch, 0);
    check("reset_rac", reset_addr_counter, 0);
    check("reset_offset", Offset_Control, 0);
    check("reset_tiles", Tiles_Control, 0);
    check("reset_err", err_timeout, 0);
    rst_n = 1'b1;

    run_batch(4'b0001, 1, 4'b0000, 4'b0000, 2, 1'b0, 3);
    run_batch(4'b1111, 2, 4'b0000, 4'b0000, -1, 1'b0, -1);
    run_batch(4'b0100, 3, 4'b0100, 4'b0000, -1, 1'b0, -1);
    run_batch(4'b0100, 1, 4'b0000, 4'b0000, -1, 1'b0, -1);
    run_batch(4'b0100, 1, 4'b0000, 4'b0100, -1, 1'b0, -1);
    run_batch(4'b0011, 1, 4'b0000, 4'b0000, -1, 1'b0, TO);

    for (int b = 0; b < 25; b++) begin
      if (b % 5 == 0) begin
        @(posedge clk);
        #1 fetch_done = 1'b1;
        @(posedge clk);
        #1 fetch_done = 1'b0;
      end
      run_batch(4'($urandom_range(1, 15)), 0, 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15) & $urandom_range(0, 15)), -1, 1'b0, -1);
    end

    run_batch(4'b0001, 1, 4'b0000, 4'b0000, -1, 1'b1, 0);
    run_batch(4'b1010, 1, 4'b0000, 4'b0000, -1, 1'b0, -1);

    for (int i = 0; i < N; i++) begin
      rem[i]     = (i == 1) ? 1 : 0;
      lk[i]      = 1'b0;
      sel_v[i]   = $urandom_range(0, 7);
      tiles_v[i] = $urandom_range(0, 1);
    end
    gen_model(4'b0000, 1'b1, 0, n);
    @(posedge clk);
    #1;
    drive_reqs(4'b0000);
    started = 1'b0;
    for (int c = 0; c < 50 && !started; c++) begin
      @(negedge clk);
      if (start_fetch) started = 1'b1;
    end
    check("reset_test_started", started, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_grant", grant, 0);
    check("async_reset_done", done, 0);
    check("async_reset_start", start_fetch, 0);
    check("async_reset_rac", reset_addr_counter, 0);
    check("async_reset_offset", Offset_Control, 0);
    check("async_reset_tiles", Tiles_Control, 0);
    check("async_reset_err", err_timeout, 0);
    req = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    m_last = N - 1;
    m_pv   = 1'b0;
    m_err  = 1'b0;
    @(posedge clk);
    #1 fetch_done = 1'b1;
    @(posedge clk);
    #1 fetch_done = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done != 0 || grant != 0) saw_done = 1'b1;
    end
    check("fetch_done_after_reset_ignored", saw_done, 0);
    check("scoreboard_after_reset", exp_q.size(), 0);
    run_batch(4'b0010, 1, 4'b0000, 4'b0000, -1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
